// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : tpu_pkg
// Brief  : Shared opcodes, FSM state encoding and instruction field offsets
//          for the Mini-TPU sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package tpu_pkg;

    // Instruction opcodes (top two bits of every instruction)
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } tpu_state_e;

    // Field offsets for {op, sel, clr, row, col, imm}. They depend on the
    // array size and data width, so they are functions of those values.
    function automatic int col_lsb(input int idx_w, input int dw);
        return dw + 0 * idx_w;
    endfunction

    function automatic int row_lsb(input int idx_w, input int dw);
        return dw + idx_w;
    endfunction

    function automatic int clr_bit(input int idx_w, input int dw);
        return dw + 2 * idx_w;
    endfunction

    function automatic int sel_bit(input int idx_w, input int dw);
        return dw + 2 * idx_w + 1;
    endfunction

    function automatic int op_lsb(input int idx_w, input int dw);
        return dw + 2 * idx_w + 2;
    endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/tpu_skew_gen.sv
`default_nettype none
// ============================================================================
// Module : tpu_skew_gen
// Brief  : Turns the run counter into skewed per-line read enables and
//          element selects. Line i is read during counter values i+1 .. i+N,
//          stepping through elements 0 .. N-1.
// Rev    : 1.0  initial release
// ============================================================================
module tpu_skew_gen #(
    parameter  int N     = 4,
    parameter  int CNT_W = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [CNT_W-1:0]   counter,
    output logic [N-1:0]       mem_rd_en,
    output logic [N*IDX_W-1:0] mem_rd_elem
);

    for (genvar i = 0; i < N; i++) begin : g_line
        localparam logic [CNT_W-1:0] C_LO     = CNT_W'(i + 1);
        localparam logic [CNT_W-1:0] C_HI     = CNT_W'(i + N);
        localparam logic [IDX_W-1:0] C_LO_IDX = IDX_W'(i + 1);

        logic [IDX_W-1:0] w_elem;

        // Window test on the full counter; the element index only needs the
        // low bits because the difference never exceeds N-1 inside the window.
        assign mem_rd_en[i] = (counter >= C_LO) && (counter <= C_HI);
        assign w_elem       = counter[IDX_W-1:0] - C_LO_IDX;
        assign mem_rd_elem[i*IDX_W +: IDX_W] = mem_rd_en[i] ? w_elem : '0;
    end

endmodule : tpu_skew_gen
`default_nettype wire

// File: rtl/tpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tpu_sequencer
// Brief  : Control unit for an N x N Mini-TPU systolic array. Decodes LOAD
//          into operand memory write strobes, STORE into a result select, and
//          runs a START/STOP sequence that drives the skewed operand reads.
// Rev    : 1.0  initial release
// ============================================================================
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter  int N          = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_W      = $clog2(N),
    localparam int INSTR_W    = 4 + 2 * IDX_W + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  busy,
    output logic                  done,
    output logic                  array_clear,
    output logic                  array_run,
    output logic [IDX_W-1:0]      array_out_row,
    output logic [IDX_W-1:0]      array_out_col,
    output logic                  store_valid,
    output logic [DATA_WIDTH-1:0] mema_wdata,
    output logic                  mema_we,
    output logic [IDX_W-1:0]      mema_wline,
    output logic [IDX_W-1:0]      mema_welem,
    output logic [DATA_WIDTH-1:0] memb_wdata,
    output logic                  memb_we,
    output logic [IDX_W-1:0]      memb_wline,
    output logic [IDX_W-1:0]      memb_welem,
    output logic [N-1:0]          mem_rd_en,
    output logic [N*IDX_W-1:0]    mem_rd_elem
);

    localparam int RUN_LEN = 3 * N - 1;
    localparam int CNT_W   = $clog2(RUN_LEN + 1);

    localparam int C_OP_LSB  = op_lsb(IDX_W, DATA_WIDTH);
    localparam int C_SEL_BIT = sel_bit(IDX_W, DATA_WIDTH);
    localparam int C_CLR_BIT = clr_bit(IDX_W, DATA_WIDTH);
    localparam int C_ROW_LSB = row_lsb(IDX_W, DATA_WIDTH);
    localparam int C_COL_LSB = col_lsb(IDX_W, DATA_WIDTH);

    localparam logic [CNT_W-1:0] C_RUN_LEN = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] C_LAST_M1 = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    tpu_state_e       r_state;
    logic [CNT_W-1:0] r_counter;

    logic [1:0]            w_op;
    logic                  w_sel;
    logic                  w_clr;
    logic [IDX_W-1:0]      w_row;
    logic [IDX_W-1:0]      w_col;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_accept;
    logic                  w_stop;
    logic                  w_load_a;
    logic                  w_load_b;
    logic                  w_store;

    // Instruction field slicing
    assign w_op  = instr[C_OP_LSB +: 2];
    assign w_sel = instr[C_SEL_BIT];
    assign w_clr = instr[C_CLR_BIT];
    assign w_row = instr[C_ROW_LSB +: IDX_W];
    assign w_col = instr[C_COL_LSB +: IDX_W];
    assign w_imm = instr[DATA_WIDTH-1:0];

    // Everything is accepted while idle; during a run only STOP gets through,
    // so LOAD/STORE/START stall until the sequencer returns to IDLE.
    assign instr_ready = (r_state == ST_IDLE) ||
                         ((r_state == ST_RUN) && (w_op == OP_STOP));
    assign w_accept    = instr_valid && instr_ready;
    assign w_stop      = w_accept && (w_op == OP_STOP);
    assign w_load_a    = w_accept && (w_op == OP_LOAD) && !w_sel;
    assign w_load_b    = w_accept && (w_op == OP_LOAD) &&  w_sel;
    assign w_store     = w_accept && (w_op == OP_STORE);

    // Run FSM with registered status outputs; done is raised one cycle early
    // so that it is high exactly while the counter holds RUN_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_counter   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            array_clear <= 1'b0;
            array_run   <= 1'b0;
        end else begin
            done        <= 1'b0;
            array_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_op == OP_START)) begin
                        busy <= 1'b1;
                        if (w_clr) begin
                            r_state     <= ST_CLEAR;
                            array_clear <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                            array_run <= 1'b1;
                            r_counter <= C_ONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_state   <= ST_RUN;
                    array_run <= 1'b1;
                    r_counter <= C_ONE;
                end
                ST_RUN: begin
                    if (w_stop || (r_counter == C_RUN_LEN)) begin
                        r_state   <= ST_IDLE;
                        r_counter <= '0;
                        busy      <= 1'b0;
                        array_run <= 1'b0;
                    end else begin
                        r_counter <= r_counter + C_ONE;
                        done      <= (r_counter == C_LAST_M1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_counter <= '0;
                    busy      <= 1'b0;
                    array_run <= 1'b0;
                end
            endcase
        end
    end

    // LOAD/STORE decode: single-cycle strobes with fields zeroed when idle.
    // Memory B is written transposed (line = col, element = row).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mema_we       <= 1'b0;
            mema_wdata    <= '0;
            mema_wline    <= '0;
            mema_welem    <= '0;
            memb_we       <= 1'b0;
            memb_wdata    <= '0;
            memb_wline    <= '0;
            memb_welem    <= '0;
            store_valid   <= 1'b0;
            array_out_row <= '0;
            array_out_col <= '0;
        end else begin
            mema_we       <= w_load_a;
            mema_wdata    <= w_load_a ? w_imm : '0;
            mema_wline    <= w_load_a ? w_row : '0;
            mema_welem    <= w_load_a ? w_col : '0;
            memb_we       <= w_load_b;
            memb_wdata    <= w_load_b ? w_imm : '0;
            memb_wline    <= w_load_b ? w_col : '0;
            memb_welem    <= w_load_b ? w_row : '0;
            store_valid   <= w_store;
            array_out_row <= w_store ? w_row : '0;
            array_out_col <= w_store ? w_col : '0;
        end
    end

    tpu_skew_gen #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_skew_gen (
        .counter     (r_counter),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_elem (mem_rd_elem)
    );

endmodule : tpu_sequencer
`default_nettype wire

// File: tb/tb_tpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_tpu_sequencer
// Brief  : Directed, table-driven bench for tpu_sequencer at N=4, DATA_WIDTH=8.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        busy, done, array_clear, array_run, store_valid;
    logic [1:0]  array_out_row, array_out_col;
    logic [7:0]  mema_wdata, memb_wdata;
    logic        mema_we, memb_we;
    logic [1:0]  mema_wline, mema_welem, memb_wline, memb_welem;
    logic [3:0]  mem_rd_en;
    logic [7:0]  mem_rd_elem;

    int n_cmp = 0;
    int n_err = 0;

    tpu_sequencer #(.N(4), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .busy          (busy),
        .done          (done),
        .array_clear   (array_clear),
        .array_run     (array_run),
        .array_out_row (array_out_row),
        .array_out_col (array_out_col),
        .store_valid   (store_valid),
        .mema_wdata    (mema_wdata),
        .mema_we       (mema_we),
        .mema_wline    (mema_wline),
        .mema_welem    (mema_welem),
        .memb_wdata    (memb_wdata),
        .memb_we       (memb_we),
        .memb_wline    (memb_wline),
        .memb_welem    (memb_welem),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_elem   (mem_rd_elem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Concatenation of every output except instr_ready; zero means all idle.
    function automatic logic [63:0] all_outs();
        return {busy, done, array_clear, array_run, array_out_row, array_out_col,
                store_valid, mema_wdata, mema_we, mema_wline, mema_welem,
                memb_wdata, memb_we, memb_wline, memb_welem, mem_rd_en, mem_rd_elem};
    endfunction

    typedef struct {
        logic [15:0] instr;
        logic        a_we;
        logic [1:0]  a_line, a_elem;
        logic [7:0]  a_data;
        logic        b_we;
        logic [1:0]  b_line, b_elem;
        logic [7:0]  b_data;
        logic        st_v;
        logic [1:0]  row, col;
    } dec_vec_t;

    typedef struct {
        int         k;
        logic [3:0] en;
        logic [7:0] elem;
        logic       busy;
        logic       done;
    } run_vec_t;

    dec_vec_t dv[8];
    run_vec_t rv[12];

    initial begin
        int         done_cnt;
        int         guard;
        int         busy_cnt;
        logic       seen_done;

        dv[0] = '{16'h895A, 1'b1, 2'd2, 2'd1, 8'h5A, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0};
        dv[1] = '{16'hA95A, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 8'h5A, 1'b0, 2'd0, 2'd0};
        dv[2] = '{16'hC600, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2};
        dv[3] = '{16'h8FFF, 1'b1, 2'd3, 2'd3, 8'hFF, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0};
        dv[4] = '{16'hB0C3, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 8'hC3, 1'b0, 2'd0, 2'd0};
        dv[5] = '{16'h4000, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0};
        dv[6] = '{16'hDB00, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3};
        dv[7] = '{16'hB6A5, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd1, 8'hA5, 1'b0, 2'd0, 2'd0};

        // k = counter value after the k-th clock of a plain START run
        rv[0]  = '{1,  4'b0001, 8'h00, 1'b1, 1'b0};
        rv[1]  = '{2,  4'b0011, 8'h01, 1'b1, 1'b0};
        rv[2]  = '{3,  4'b0111, 8'h06, 1'b1, 1'b0};
        rv[3]  = '{4,  4'b1111, 8'h1B, 1'b1, 1'b0};
        rv[4]  = '{5,  4'b1110, 8'h6C, 1'b1, 1'b0};
        rv[5]  = '{6,  4'b1100, 8'hB0, 1'b1, 1'b0};
        rv[6]  = '{7,  4'b1000, 8'hC0, 1'b1, 1'b0};
        rv[7]  = '{8,  4'b0000, 8'h00, 1'b1, 1'b0};
        rv[8]  = '{9,  4'b0000, 8'h00, 1'b1, 1'b0};
        rv[9]  = '{10, 4'b0000, 8'h00, 1'b1, 1'b0};
        rv[10] = '{11, 4'b0000, 8'h00, 1'b1, 1'b1};
        rv[11] = '{12, 4'b0000, 8'h00, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(all_outs() != 64'd0), 32'd0);
        chk("reset_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD/STORE/STOP decode vectors issued in IDLE
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            instr = dv[v].instr;
            instr_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("a_we",    32'(mema_we),       32'(dv[v].a_we));
            chk("a_line",  32'(mema_wline),    32'(dv[v].a_line));
            chk("a_elem",  32'(mema_welem),    32'(dv[v].a_elem));
            chk("a_data",  32'(mema_wdata),    32'(dv[v].a_data));
            chk("b_we",    32'(memb_we),       32'(dv[v].b_we));
            chk("b_line",  32'(memb_wline),    32'(dv[v].b_line));
            chk("b_elem",  32'(memb_welem),    32'(dv[v].b_elem));
            chk("b_data",  32'(memb_wdata),    32'(dv[v].b_data));
            chk("st_valid",32'(store_valid),   32'(dv[v].st_v));
            chk("st_row",  32'(array_out_row), 32'(dv[v].row));
            chk("st_col",  32'(array_out_col), 32'(dv[v].col));
            chk("dec_busy",32'(busy),          32'd0);
            @(negedge clk);
            instr_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("strobe_width", 32'({mema_we, memb_we, store_valid}), 32'd0);
        end

        // Plain START run, checked cycle by cycle
        @(negedge clk);
        instr = 16'h0000;
        instr_valid = 1'b1;
        for (int r = 0; r < 12; r++) begin
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            chk($sformatf("rd_en_k%0d", rv[r].k),   32'(mem_rd_en),   32'(rv[r].en));
            chk($sformatf("rd_elem_k%0d", rv[r].k), 32'(mem_rd_elem), 32'(rv[r].elem));
            chk($sformatf("busy_k%0d", rv[r].k),    32'(busy),        32'(rv[r].busy));
            chk($sformatf("done_k%0d", rv[r].k),    32'(done),        32'(rv[r].done));
            chk($sformatf("run_k%0d", rv[r].k),     32'(array_run),   32'(rv[r].busy));
        end
        chk("idle_ready", 32'(instr_ready), 32'd1);

        // START with clear: one clear cycle, then RUN; busy lasts 12 cycles
        @(negedge clk);
        instr = 16'h1000;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_pulse", 32'({array_clear, array_run, busy}), 32'b101);
        chk("clr_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_then_run", 32'({array_clear, array_run, busy}), 32'b011);
        busy_cnt = 2;
        seen_done = 1'b0;
        guard = 0;
        while (!seen_done && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
            if (busy) busy_cnt++;
            if (done) seen_done = 1'b1;
        end
        chk("clr_done_seen", 32'(seen_done), 32'd1);
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd12);

        // Back-to-back START held from the done cycle onward
        @(negedge clk);
        instr = 16'h0000;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_idle", 32'({busy, instr_ready}), 32'b01);
        @(posedge clk);
        #1;
        chk("b2b_start", 32'({busy, mem_rd_en}), 32'b10001);

        // LOAD presented during the run stalls until STOP at counter 5
        @(negedge clk);
        instr = 16'h895A;
        done_cnt = 0;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("load_stall_k%0d", k), 32'({instr_ready, mema_we}), 32'd0);
            done_cnt += int'(done);
        end
        chk("k5_rd_en", 32'(mem_rd_en), 32'b1110);
        @(negedge clk);
        instr = 16'h4000;
        #1;
        chk("stop_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("stop_idle", 32'({busy, array_run, mem_rd_en}), 32'd0);
        @(negedge clk);
        instr = 16'h895A;
        @(posedge clk);
        #1;
        chk("load_after_stop", 32'({mema_we, mema_wline, mema_welem}), 32'b11001);
        @(negedge clk);
        instr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            done_cnt += int'(done);
        end
        chk("stop_no_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset at counter 6
        @(negedge clk);
        instr = 16'h0000;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("k6_rd_en", 32'(mem_rd_en), 32'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(all_outs() != 64'd0), 32'd0);
        chk("async_rst_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tpu_sequencer
`default_nettype wire
